// File: rtl/calc_pkg.sv
// calc_pkg: shared FSM state encoding and width helper for the calculator datapath
package calc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/seq_divider_core.sv
// seq_divider_core: unsigned restoring divider datapath (clk, rst, load, step, dividend, divisor -> quo, rem_out, last)
module seq_divider_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem_out,
  output logic             last
);
  import calc_pkg::*;
  localparam int CW = clog2(WIDTH);
  logic [WIDTH:0] pr;
  logic [WIDTH-1:0] qr, d;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] trial;
  logic ge;
  // qr doubles as the dividend shift register: its MSB feeds the remainder while quotient bits enter at the LSB
  always_comb begin
    trial = {pr[WIDTH-1:0], qr[WIDTH-1]};
    ge = {pr, qr[WIDTH-1]} >= {2'b00, d};
    last = cnt == CW'(WIDTH - 1);
    quo = qr;
    rem_out = pr[WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pr <= '0;
      qr <= '0;
      d <= '0;
      cnt <= '0;
    end else if (load) begin
      pr <= '0;
      qr <= dividend;
      d <= divisor;
      cnt <= '0;
    end else if (step) begin
      pr <= ge ? trial - {1'b0, d} : trial;
      qr <= {qr[WIDTH-2:0], ge};
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential signed/unsigned divider (start/busy/done handshake; a, b -> quotient, remainder, div_by_zero)
module seq_divider #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done
);
  import calc_pkg::*;
  state_t state, state_n;
  logic sm, a_neg, b_neg, b_zero, accept, neg_q, neg_r, last;
  logic [WIDTH-1:0] mag_a, mag_b, cq, cr;
  // min negative negates to itself, which is its correct unsigned magnitude
  always_comb begin
    sm = signed_mode & SIGNED_EN;
    a_neg = sm & a[WIDTH-1];
    b_neg = sm & b[WIDTH-1];
    mag_a = a_neg ? -a : a;
    mag_b = b_neg ? -b : b;
    b_zero = b == '0;
    busy = state != IDLE;
    done = state == DONE;
    accept = start & ~busy;
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (b_zero ? DONE : CALC) : IDLE;
      CALC:    state_n = last ? FIX : CALC;
      FIX:     state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // outputs are written on entry to DONE so they are valid during the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
      end
      if (accept && b_zero) begin
        quotient <= '1;
        remainder <= a;
        div_by_zero <= 1'b1;
      end
      if (state == FIX) begin
        quotient <= neg_q ? -cq : cq;
        remainder <= neg_r ? -cr : cr;
        div_by_zero <= 1'b0;
      end
    end
  end
  seq_divider_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk),
    .rst(rst),
    .load(accept & ~b_zero),
    .step(state == CALC),
    .dividend(mag_a),
    .divisor(mag_b),
    .quo(cq),
    .rem_out(cr),
    .last(last)
  );
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed check of seq_divider against an arithmetic reference model
module tb_seq_divider;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, signed_mode = 1'b0;
  logic [7:0] a = '0, b = '0, quotient, remainder;
  logic div_by_zero, busy, done;
  int total = 0, bad = 0;
  seq_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .signed_mode(signed_mode),
    .a(a),
    .b(b),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero),
    .busy(busy),
    .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic model(input logic [7:0] aa, input logic [7:0] bb, input logic s,
                       output logic [7:0] q, output logic [7:0] r, output logic dz);
    int sa, sb;
    sa = s ? int'($signed(aa)) : int'(aa);
    sb = s ? int'($signed(bb)) : int'(bb);
    if (bb == 8'd0) begin
      q = 8'hFF;
      r = aa;
      dz = 1'b1;
    end else begin
      q = 8'(sa / sb);
      r = 8'(sa % sb);
      dz = 1'b0;
    end
  endtask
  task automatic op(input logic [7:0] aa, input logic [7:0] bb, input logic s, input bit poke);
    logic [7:0] eq, er;
    logic ed;
    int k, busy_lo, extra;
    model(aa, bb, s, eq, er, ed);
    @(negedge clk);
    a = aa;
    b = bb;
    signed_mode = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    signed_mode = 1'($urandom);
    k = 1;
    busy_lo = 0;
    while (!done && k < 40) begin
      if (!busy) busy_lo++;
      start = poke && k == 2;
      if (start) begin
        a = 8'd50;
        b = 8'd5;
      end
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    chk("latency", k, ed ? 1 : 10);
    chk("busy_window", busy_lo, 0);
    chk("busy_at_done", busy, 1);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, ed);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_clear", busy, 0);
    chk("hold_q", quotient, eq);
    if (poke) begin
      extra = 0;
      repeat (12) begin
        @(negedge clk);
        if (done) extra++;
      end
      chk("extra_done", extra, 0);
    end
  endtask
  initial begin
    logic [7:0] ra, rb;
    repeat (3) @(negedge clk);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    op(8'd200, 8'd7, 1'b0, 1'b0);
    op(8'hF9, 8'h02, 1'b1, 1'b0);
    op(8'h07, 8'hFE, 1'b1, 1'b0);
    op(8'h35, 8'h00, 1'b0, 1'b0);
    op(8'd9, 8'd3, 1'b0, 1'b0);
    op(8'h80, 8'hFF, 1'b1, 1'b0);
    op(8'h80, 8'hFF, 1'b0, 1'b0);
    op(8'h80, 8'h00, 1'b1, 1'b0);
    op(8'd100, 8'd10, 1'b0, 1'b1);
    @(negedge clk);
    a = 8'd200;
    b = 8'd7;
    signed_mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_q", quotient, 0);
    chk("mid_rst_r", remainder, 0);
    chk("mid_rst_dz", div_by_zero, 0);
    op(8'd15, 8'd4, 1'b0, 1'b0);
    repeat (60) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      op(ra, rb, 1'($urandom), 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
